// File: rtl/issue_queue_if.sv
// Rename-to-issue enqueue bundle, writeback wakeup broadcast and
// issue-to-execute output slot for the issue queue.
interface issue_queue_if #(
    parameter int PHYS_BITS = 6,
    parameter int INSTR_W   = 32,
    parameter int NUM_WB    = 2,
    parameter int CNT_W     = 5
);
    logic                        in_valid;
    logic                        in_ready;
    logic [INSTR_W-1:0]          in_instr;
    logic [PHYS_BITS-1:0]        in_rd_phys;
    logic [PHYS_BITS-1:0]        in_rs_phys;
    logic [PHYS_BITS-1:0]        in_rt_phys;
    logic                        in_uses_rs;
    logic                        in_uses_rt;
    logic                        in_rs_busy;
    logic                        in_rt_busy;
    logic [NUM_WB-1:0]           wb_valid;
    logic [NUM_WB*PHYS_BITS-1:0] wb_phys;
    logic                        flush;
    logic                        issue_valid;
    logic                        issue_ready;
    logic [INSTR_W-1:0]          issue_instr;
    logic [PHYS_BITS-1:0]        issue_rd_phys;
    logic [PHYS_BITS-1:0]        issue_rs_phys;
    logic [PHYS_BITS-1:0]        issue_rt_phys;
    logic [CNT_W-1:0]            count;

    modport slave (
        input  in_valid, in_instr, in_rd_phys, in_rs_phys, in_rt_phys,
        input  in_uses_rs, in_uses_rt, in_rs_busy, in_rt_busy,
        input  wb_valid, wb_phys, flush, issue_ready,
        output in_ready, issue_valid, issue_instr,
        output issue_rd_phys, issue_rs_phys, issue_rt_phys, count
    );

    modport master (
        output in_valid, in_instr, in_rd_phys, in_rs_phys, in_rt_phys,
        output in_uses_rs, in_uses_rt, in_rs_busy, in_rt_busy,
        output wb_valid, wb_phys, flush, issue_ready,
        input  in_ready, issue_valid, issue_instr,
        input  issue_rd_phys, issue_rs_phys, issue_rt_phys, count
    );
endinterface

// File: rtl/issue_queue.sv
// Compacting out-of-order issue queue: entry 0 is oldest, tags wake on
// writeback broadcast, oldest fully-ready entry moves into the output slot.
module issue_queue #(
    parameter int PHYS_BITS = 6,
    parameter int IQ_DEPTH  = 16,
    parameter int INSTR_W   = 32,
    parameter int NUM_WB    = 2
) (
    input  logic          clk,
    input  logic          rst,
    issue_queue_if.slave  io
);
    localparam int IW = $clog2(IQ_DEPTH);
    localparam int CW = IW + 1;

    typedef logic [PHYS_BITS-1:0] tag_t;

    logic [INSTR_W-1:0] instr_q  [IQ_DEPTH];
    tag_t               rd_q     [IQ_DEPTH];
    tag_t               rs_q     [IQ_DEPTH];
    tag_t               rt_q     [IQ_DEPTH];
    logic               rs_rdy_q [IQ_DEPTH];
    logic               rt_rdy_q [IQ_DEPTH];

    logic [INSTR_W-1:0] instr_d  [IQ_DEPTH];
    tag_t               rd_d     [IQ_DEPTH];
    tag_t               rs_d     [IQ_DEPTH];
    tag_t               rt_d     [IQ_DEPTH];
    logic               rs_rdy_d [IQ_DEPTH];
    logic               rt_rdy_d [IQ_DEPTH];

    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [CW-1:0]      cnt_s;

    logic               iv_q;
    logic [INSTR_W-1:0] iss_instr_q;
    tag_t               iss_rd_q;
    tag_t               iss_rs_q;
    tag_t               iss_rt_q;

    logic               in_ready;
    logic               loadable;
    logic               found;
    logic [IW-1:0]      sel;
    logic               do_issue;
    logic               enq;

    function automatic logic wb_hit(
        input tag_t                        tag,
        input logic [NUM_WB-1:0]           wv,
        input logic [NUM_WB*PHYS_BITS-1:0] wp
    );
        wb_hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wv[k] && wp[k*PHYS_BITS +: PHYS_BITS] == tag) begin
                wb_hit = 1'b1;
            end
        end
    endfunction

    assign in_ready = (count_q != CW'(IQ_DEPTH));
    assign loadable = !iv_q || io.issue_ready;
    assign do_issue = loadable && found;
    assign enq      = io.in_valid && in_ready;
    assign cnt_s    = count_q - CW'(do_issue);
    assign count_d  = cnt_s + CW'(enq);

    // Descending scan leaves the lowest ready index in sel.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < count_q && rs_rdy_q[i] && rt_rdy_q[i]) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    // Shift over the issued entry, wake survivors, then append at cnt_s.
    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (do_issue && IW'(i) >= sel && i < IQ_DEPTH - 1) begin
                instr_d[i]  = instr_q[IW'((i + 1) % IQ_DEPTH)];
                rd_d[i]     = rd_q[IW'((i + 1) % IQ_DEPTH)];
                rs_d[i]     = rs_q[IW'((i + 1) % IQ_DEPTH)];
                rt_d[i]     = rt_q[IW'((i + 1) % IQ_DEPTH)];
                rs_rdy_d[i] = rs_rdy_q[IW'((i + 1) % IQ_DEPTH)];
                rt_rdy_d[i] = rt_rdy_q[IW'((i + 1) % IQ_DEPTH)];
            end else begin
                instr_d[i]  = instr_q[i];
                rd_d[i]     = rd_q[i];
                rs_d[i]     = rs_q[i];
                rt_d[i]     = rt_q[i];
                rs_rdy_d[i] = rs_rdy_q[i];
                rt_rdy_d[i] = rt_rdy_q[i];
            end
            if (wb_hit(rs_d[i], io.wb_valid, io.wb_phys)) rs_rdy_d[i] = 1'b1;
            if (wb_hit(rt_d[i], io.wb_valid, io.wb_phys)) rt_rdy_d[i] = 1'b1;
            if (enq && CW'(i) == cnt_s) begin
                instr_d[i]  = io.in_instr;
                rd_d[i]     = io.in_rd_phys;
                rs_d[i]     = io.in_rs_phys;
                rt_d[i]     = io.in_rt_phys;
                rs_rdy_d[i] = !io.in_uses_rs || !io.in_rs_busy ||
                              wb_hit(io.in_rs_phys, io.wb_valid, io.wb_phys);
                rt_rdy_d[i] = !io.in_uses_rt || !io.in_rt_busy ||
                              wb_hit(io.in_rt_phys, io.wb_valid, io.wb_phys);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            iv_q        <= 1'b0;
            iss_instr_q <= '0;
            iss_rd_q    <= '0;
            iss_rs_q    <= '0;
            iss_rt_q    <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                instr_q[i]  <= '0;
                rd_q[i]     <= '0;
                rs_q[i]     <= '0;
                rt_q[i]     <= '0;
                rs_rdy_q[i] <= 1'b0;
                rt_rdy_q[i] <= 1'b0;
            end
        end else if (io.flush) begin
            count_q <= '0;
            iv_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                instr_q[i]  <= instr_d[i];
                rd_q[i]     <= rd_d[i];
                rs_q[i]     <= rs_d[i];
                rt_q[i]     <= rt_d[i];
                rs_rdy_q[i] <= rs_rdy_d[i];
                rt_rdy_q[i] <= rt_rdy_d[i];
            end
            if (loadable) begin
                iv_q <= found;
                if (found) begin
                    iss_instr_q <= instr_q[sel];
                    iss_rd_q    <= rd_q[sel];
                    iss_rs_q    <= rs_q[sel];
                    iss_rt_q    <= rt_q[sel];
                end
            end
        end
    end

    assign io.in_ready      = in_ready;
    assign io.issue_valid   = iv_q;
    assign io.issue_instr   = iss_instr_q;
    assign io.issue_rd_phys = iss_rd_q;
    assign io.issue_rs_phys = iss_rs_q;
    assign io.issue_rt_phys = iss_rt_q;
    assign io.count         = count_q;
endmodule
